// File: rtl/branch_checkpoint_stack.sv
// Branch checkpoint stack: free-list snapshots per in-flight branch, retire merge, restore on mispredict.
// Optional BCS_DEBUG_EN adds debug_valid/debug_snaps ports and a stack dump on every kill.
module branch_checkpoint_stack #(
  parameter int DEPTH            = 4,
  parameter int PHYS_REG_SZ_R10K = 64,
  parameter int PHYS_REG_IDX     = 6,
  parameter int N                = 2,
  parameter int NUM_SCALAR_BITS  = 2
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  dispatch_branch,
  input  logic [PHYS_REG_SZ_R10K-1:0]           dispatch_free_list,
  input  logic [N-1:0][PHYS_REG_IDX-1:0]        phys_reg_retiring,
  input  logic [NUM_SCALAR_BITS-1:0]            num_retiring_valid,
  input  logic                                  resolve_valid,
  input  logic [DEPTH-1:0]                      resolve_tag,
  input  logic                                  resolve_mispredict,
  output logic [DEPTH-1:0]                      alloc_tag,
  output logic                                  stack_full,
  output logic [DEPTH-1:0]                      branch_mask,
  output logic [DEPTH-1:0]                      squash_mask,
  output logic [PHYS_REG_SZ_R10K-1:0]           free_list_restore,
  output logic                                  restore_flag
`ifdef BCS_DEBUG_EN
  ,
  output logic [DEPTH-1:0]                      debug_valid,
  output logic [DEPTH-1:0][PHYS_REG_SZ_R10K-1:0] debug_snaps
`endif
);

  logic [DEPTH-1:0]                        valid;
  logic [DEPTH-1:0][DEPTH-1:0]             older;
  logic [DEPTH-1:0][PHYS_REG_SZ_R10K-1:0]  snap;

  logic [PHYS_REG_SZ_R10K-1:0] retire_bits;
  logic [PHYS_REG_SZ_R10K-1:0] sel_snap;
  logic [DEPTH-1:0]            younger;
  logic [DEPTH-1:0]            clr_mask;
  logic                        tag_onehot;
  logic                        tag_live;
  logic                        res_ok;
  logic                        kill;
  logic                        do_alloc;

  always_comb begin
    retire_bits = '0;
    for (int i = 0; i < N; i++) begin
      if (i < int'(num_retiring_valid)) retire_bits[phys_reg_retiring[i]] = 1'b1;
    end
  end

  // Malformed or stale tags are dropped entirely so they can never corrupt the stack.
  assign tag_onehot = $onehot(resolve_tag);
  assign tag_live   = |(resolve_tag & valid);
  assign res_ok     = resolve_valid & tag_onehot & tag_live;
  assign kill       = res_ok & resolve_mispredict;
  assign clr_mask   = (res_ok & ~resolve_mispredict) ? resolve_tag : '0;

  always_comb begin
    alloc_tag = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid[i] && alloc_tag == '0) alloc_tag[i] = 1'b1;
    end
  end

  assign stack_full  = &valid;
  assign branch_mask = valid;
  assign do_alloc    = dispatch_branch & ~stack_full & ~kill;

  always_comb begin
    younger  = '0;
    sel_snap = '0;
    for (int j = 0; j < DEPTH; j++) begin
      younger[j] = valid[j] & |(older[j] & resolve_tag);
      if (resolve_tag[j]) sel_snap = sel_snap | snap[j];
    end
  end

  assign restore_flag      = kill & ~reset;
  assign squash_mask       = restore_flag ? (resolve_tag | younger) : '0;
  assign free_list_restore = restore_flag ? (sel_snap | retire_bits) : '0;

  // An allocated slot is never the one being resolved or squashed in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
      older <= '0;
      snap  <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        if (do_alloc && alloc_tag[j]) begin
          valid[j] <= 1'b1;
          snap[j]  <= dispatch_free_list | retire_bits;
          older[j] <= valid & ~clr_mask;
        end else begin
          if (valid[j]) snap[j] <= snap[j] | retire_bits;
          older[j] <= older[j] & ~clr_mask;
          if (clr_mask[j] || squash_mask[j]) valid[j] <= 1'b0;
        end
      end
    end
  end

`ifdef BCS_DEBUG_EN
  assign debug_valid = valid;
  assign debug_snaps = snap;
`endif

`ifndef SYNTHESIS
  illegal_resolve_tag: assert property (@(posedge clock) disable iff (reset)
    resolve_valid |-> (tag_onehot && tag_live))
    else $warning("branch_checkpoint_stack: resolve tag %b ignored (live %b)", resolve_tag, valid);

`ifdef BCS_DEBUG_EN
  always_ff @(posedge clock) begin
    if (!reset && kill) begin
      $display("bcs kill tag=%b squash=%b valid=%b", resolve_tag, squash_mask, valid);
      for (int j = 0; j < DEPTH; j++) begin
        $display("  slot %0d v=%b older=%b snap=%h", j, valid[j], older[j], snap[j]);
      end
    end
  end
`endif
`endif

endmodule

// File: tb/tb_branch_checkpoint_stack.sv
// Directed, table-driven bench for branch_checkpoint_stack with hand-computed expectations.
module tb_branch_checkpoint_stack;

  localparam int DEPTH = 4;
  localparam int PSZ   = 64;
  localparam int PIDX  = 6;
  localparam int NRET  = 2;
  localparam int NSB   = 2;
  localparam int NVEC  = 28;

  logic                       clock = 1'b0;
  logic                       reset;
  logic                       dispatch_branch;
  logic [PSZ-1:0]             dispatch_free_list;
  logic [NRET-1:0][PIDX-1:0]  phys_reg_retiring;
  logic [NSB-1:0]             num_retiring_valid;
  logic                       resolve_valid;
  logic [DEPTH-1:0]           resolve_tag;
  logic                       resolve_mispredict;
  logic [DEPTH-1:0]           alloc_tag;
  logic                       stack_full;
  logic [DEPTH-1:0]           branch_mask;
  logic [DEPTH-1:0]           squash_mask;
  logic [PSZ-1:0]             free_list_restore;
  logic                       restore_flag;

  always #5 clock = ~clock;

  branch_checkpoint_stack #(
    .DEPTH(DEPTH), .PHYS_REG_SZ_R10K(PSZ), .PHYS_REG_IDX(PIDX), .N(NRET), .NUM_SCALAR_BITS(NSB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .dispatch_branch(dispatch_branch),
    .dispatch_free_list(dispatch_free_list),
    .phys_reg_retiring(phys_reg_retiring),
    .num_retiring_valid(num_retiring_valid),
    .resolve_valid(resolve_valid),
    .resolve_tag(resolve_tag),
    .resolve_mispredict(resolve_mispredict),
    .alloc_tag(alloc_tag),
    .stack_full(stack_full),
    .branch_mask(branch_mask),
    .squash_mask(squash_mask),
    .free_list_restore(free_list_restore),
    .restore_flag(restore_flag)
  );

  typedef struct {
    logic            disp;
    logic [PSZ-1:0]  dfl;
    logic [PIDX-1:0] r0;
    logic [PIDX-1:0] r1;
    logic [NSB-1:0]  nret;
    logic            rv;
    logic [3:0]      rtag;
    logic            rmis;
    logic [3:0]      e_alloc;
    logic            e_full;
    logic [3:0]      e_mask;
    logic [3:0]      e_sq;
    logic            e_rf;
    logic [PSZ-1:0]  e_flr;
  } vec_t;

  vec_t vec[NVEC];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic disp, logic [PSZ-1:0] dfl, logic [PIDX-1:0] r0, logic [PIDX-1:0] r1,
                              logic [NSB-1:0] nret, logic rv, logic [3:0] rtag, logic rmis,
                              logic [3:0] e_alloc, logic e_full, logic [3:0] e_mask, logic [3:0] e_sq,
                              logic e_rf, logic [PSZ-1:0] e_flr);
    vec_t v;
    v.disp = disp; v.dfl = dfl; v.r0 = r0; v.r1 = r1; v.nret = nret;
    v.rv = rv; v.rtag = rtag; v.rmis = rmis;
    v.e_alloc = e_alloc; v.e_full = e_full; v.e_mask = e_mask; v.e_sq = e_sq;
    v.e_rf = e_rf; v.e_flr = e_flr;
    return v;
  endfunction

  task automatic chk(string name, logic [PSZ-1:0] act, logic [PSZ-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    dispatch_branch    = 1'b0;
    dispatch_free_list = '0;
    phys_reg_retiring  = '0;
    num_retiring_valid = '0;
    resolve_valid      = 1'b0;
    resolve_tag        = '0;
    resolve_mispredict = 1'b0;
  endtask

  localparam logic [PSZ-1:0] F0  = 64'h1234_0000_0000_0001;
  localparam logic [PSZ-1:0] F1  = 64'h0000_0000_0000_F000;
  localparam logic [PSZ-1:0] F2  = 64'h00FF_0000_0000_0000;
  localparam logic [PSZ-1:0] F3  = 64'h0000_0000_0F0F_0000;
  localparam logic [PSZ-1:0] F4  = 64'h8000_0000_0000_0000;
  localparam logic [PSZ-1:0] F5  = 64'h0000_00AA_0000_0000;
  localparam logic [PSZ-1:0] G0  = 64'h0000_0000_0000_0003;
  localparam logic [PSZ-1:0] G1  = 64'hDEAD_BEEF_0000_0000;
  localparam logic [PSZ-1:0] G2  = 64'h0000_0000_5555_0000;
  localparam logic [PSZ-1:0] G3  = 64'h0000_0000_0000_7700;
  localparam logic [PSZ-1:0] H0  = 64'h0101_0101_0000_0000;
  localparam logic [PSZ-1:0] H1  = 64'h0000_0000_1010_1010;
  localparam logic [PSZ-1:0] H2  = 64'h0000_0000_CAFE_0000;
  localparam logic [PSZ-1:0] Z   = 64'h0;

  initial begin
    //            disp dfl r0  r1  n  rv rtag     rmis alloc    full mask     sq       rf flr
    vec[0]  = mk(0, Z,  0,  0,  0, 0, 4'b0000, 0, 4'b0001, 0, 4'b0000, 4'b0000, 0, Z);
    vec[1]  = mk(0, Z,  0,  0,  0, 0, 4'b0000, 0, 4'b0001, 0, 4'b0000, 4'b0000, 0, Z);
    vec[2]  = mk(1, F0, 0,  0,  0, 0, 4'b0000, 0, 4'b0001, 0, 4'b0000, 4'b0000, 0, Z);
    vec[3]  = mk(1, F1, 0,  0,  0, 0, 4'b0000, 0, 4'b0010, 0, 4'b0001, 4'b0000, 0, Z);
    vec[4]  = mk(1, F2, 0,  0,  0, 0, 4'b0000, 0, 4'b0100, 0, 4'b0011, 4'b0000, 0, Z);
    vec[5]  = mk(1, F3, 0,  0,  0, 0, 4'b0000, 0, 4'b1000, 0, 4'b0111, 4'b0000, 0, Z);
    vec[6]  = mk(1, F4, 0,  0,  0, 0, 4'b0000, 0, 4'b0000, 1, 4'b1111, 4'b0000, 0, Z);
    vec[7]  = mk(0, Z,  0,  0,  0, 0, 4'b0000, 0, 4'b0000, 1, 4'b1111, 4'b0000, 0, Z);
    // full: correct resolve with a dispatch stalls the dispatch this cycle
    vec[8]  = mk(1, F4, 0,  0,  0, 1, 4'b0010, 0, 4'b0000, 1, 4'b1111, 4'b0000, 0, Z);
    vec[9]  = mk(1, F5, 0,  0,  0, 0, 4'b0000, 0, 4'b0010, 0, 4'b1101, 4'b0000, 0, Z);
    vec[10] = mk(0, Z,  5,  9,  2, 0, 4'b0000, 0, 4'b0000, 1, 4'b1111, 4'b0000, 0, Z);
    vec[11] = mk(0, Z,  5,  9,  2, 0, 4'b0000, 0, 4'b0000, 1, 4'b1111, 4'b0000, 0, Z);
    // mispredict oldest: F0 | bit5 | bit9 | same-cycle retire bit12
    vec[12] = mk(1, F4, 12, 0,  1, 1, 4'b0001, 1, 4'b0000, 1, 4'b1111, 4'b1111, 1, 64'h1234_0000_0000_1221);
    vec[13] = mk(0, Z,  0,  0,  0, 0, 4'b0000, 0, 4'b0001, 0, 4'b0000, 4'b0000, 0, Z);
    vec[14] = mk(1, G0, 0,  0,  0, 0, 4'b0000, 0, 4'b0001, 0, 4'b0000, 4'b0000, 0, Z);
    vec[15] = mk(1, G1, 0,  0,  0, 0, 4'b0000, 0, 4'b0010, 0, 4'b0001, 4'b0000, 0, Z);
    vec[16] = mk(1, G2, 0,  0,  0, 0, 4'b0000, 0, 4'b0100, 0, 4'b0011, 4'b0000, 0, Z);
    // mispredict middle tag with a wrong-path dispatch in the same cycle
    vec[17] = mk(1, G3, 0,  0,  0, 1, 4'b0010, 1, 4'b1000, 0, 4'b0111, 4'b0110, 1, G1);
    vec[18] = mk(0, Z,  0,  0,  0, 0, 4'b0000, 0, 4'b0010, 0, 4'b0001, 4'b0000, 0, Z);
    vec[19] = mk(0, Z,  0,  0,  0, 1, 4'b0001, 0, 4'b0010, 0, 4'b0001, 4'b0000, 0, Z);
    vec[20] = mk(0, Z,  0,  0,  0, 0, 4'b0000, 0, 4'b0001, 0, 4'b0000, 4'b0000, 0, Z);
    vec[21] = mk(1, H0, 0,  0,  0, 0, 4'b0000, 0, 4'b0001, 0, 4'b0000, 4'b0000, 0, Z);
    vec[22] = mk(1, H1, 0,  0,  0, 0, 4'b0000, 0, 4'b0010, 0, 4'b0001, 4'b0000, 0, Z);
    // non-one-hot tag, then a one-hot tag that is not live: both ignored
    vec[23] = mk(0, Z,  0,  0,  0, 1, 4'b0011, 1, 4'b0100, 0, 4'b0011, 4'b0000, 0, Z);
    vec[24] = mk(0, Z,  0,  0,  0, 1, 4'b0100, 1, 4'b0100, 0, 4'b0011, 4'b0000, 0, Z);
    // snapshot includes retire of the capture cycle (bit40)
    vec[25] = mk(1, H2, 40, 0,  1, 0, 4'b0000, 0, 4'b0100, 0, 4'b0011, 4'b0000, 0, Z);
    // num_retiring_valid=0: listed regs must not merge
    vec[26] = mk(0, Z,  50, 51, 0, 1, 4'b0100, 1, 4'b1000, 0, 4'b0111, 4'b0100, 1, 64'h0000_0100_CAFE_0000);
    vec[27] = mk(0, Z,  0,  0,  0, 0, 4'b0000, 0, 4'b0100, 0, 4'b0011, 4'b0000, 0, Z);

    drive_idle();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #2;
    chk("reset_branch_mask", PSZ'(branch_mask), PSZ'(4'b0000));
    chk("reset_alloc_tag", PSZ'(alloc_tag), PSZ'(4'b0001));
    chk("reset_stack_full", PSZ'(stack_full), PSZ'(1'b0));
    chk("reset_restore_flag", PSZ'(restore_flag), PSZ'(1'b0));
    @(negedge clock);
    reset = 1'b0;

    for (int k = 0; k < NVEC; k++) begin
      dispatch_branch      = vec[k].disp;
      dispatch_free_list   = vec[k].dfl;
      phys_reg_retiring[0] = vec[k].r0;
      phys_reg_retiring[1] = vec[k].r1;
      num_retiring_valid   = vec[k].nret;
      resolve_valid        = vec[k].rv;
      resolve_tag          = vec[k].rtag;
      resolve_mispredict   = vec[k].rmis;
      #2;
      chk($sformatf("v%0d_alloc_tag", k), PSZ'(alloc_tag), PSZ'(vec[k].e_alloc));
      chk($sformatf("v%0d_stack_full", k), PSZ'(stack_full), PSZ'(vec[k].e_full));
      chk($sformatf("v%0d_branch_mask", k), PSZ'(branch_mask), PSZ'(vec[k].e_mask));
      chk($sformatf("v%0d_squash_mask", k), PSZ'(squash_mask), PSZ'(vec[k].e_sq));
      chk($sformatf("v%0d_restore_flag", k), PSZ'(restore_flag), PSZ'(vec[k].e_rf));
      chk($sformatf("v%0d_free_list_restore", k), free_list_restore, vec[k].e_flr);
      @(negedge clock);
    end

    // Reset mid-operation with a mispredict pending: no restore, everything cleared.
    drive_idle();
    reset              = 1'b1;
    resolve_valid      = 1'b1;
    resolve_tag        = 4'b0001;
    resolve_mispredict = 1'b1;
    #2;
    chk("midreset_restore_flag", PSZ'(restore_flag), PSZ'(1'b0));
    chk("midreset_squash_mask", PSZ'(squash_mask), PSZ'(4'b0000));
    chk("midreset_free_list_restore", free_list_restore, Z);
    chk("midreset_mask_before_edge", PSZ'(branch_mask), PSZ'(4'b0011));
    @(negedge clock);
    drive_idle();
    reset = 1'b0;
    #2;
    chk("postreset_branch_mask", PSZ'(branch_mask), PSZ'(4'b0000));
    chk("postreset_alloc_tag", PSZ'(alloc_tag), PSZ'(4'b0001));

    // Freshly allocated slot after reset must hold the new snapshot, not stale data.
    dispatch_branch    = 1'b1;
    dispatch_free_list = 64'h0000_0000_0000_0F00;
    @(negedge clock);
    drive_idle();
    resolve_valid      = 1'b1;
    resolve_tag        = 4'b0001;
    resolve_mispredict = 1'b1;
    #2;
    chk("postreset_restore_flag", PSZ'(restore_flag), PSZ'(1'b1));
    chk("postreset_free_list_restore", free_list_restore, 64'h0000_0000_0000_0F00);
    @(negedge clock);
    drive_idle();
    #2;
    chk("final_branch_mask", PSZ'(branch_mask), PSZ'(4'b0000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
